// File: rtl/sd_spi_pkg.sv
// rtl/sd_spi_pkg.sv - shared SD SPI-mode command indices, R1 layout, FSM states and response lengths
package sd_spi_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE_BIT    = 0;
  localparam int R1_ILLEGAL_BIT = 2;

  localparam int R1_LEN   = 1;
  localparam int R3_LEN   = 5;
  localparam int R7_LEN   = 5;
  localparam int RESP_MAX = 5;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_ARG,
    ST_CRC,
    ST_RESP
  } frame_state_t;

  function automatic logic [7:0] r1_byte(input logic idle, input logic illegal);
    logic [7:0] r;
    r = 8'h00;
    r[R1_IDLE_BIT]    = idle;
    r[R1_ILLEGAL_BIT] = illegal;
    return r;
  endfunction

endpackage

// File: rtl/sd_spi_byte_io.sv
// rtl/sd_spi_byte_io.sv - oversampled SPI mode-0 byte transceiver (synchronisers, edge detect, shift registers)
module sd_spi_byte_io (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       selected,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  input  logic [7:0] tx_byte,
  output logic       tx_load
);

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_prev;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       sclk_rise;
  logic       sclk_fall;

  assign selected  = ~cs_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign spi_miso  = tx_shift[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], spi_sclk};
      cs_sync   <= {cs_sync[0], spi_cs_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sclk_prev <= sclk_sync[1];
    end
  end

  // The next byte is fetched on the fall that ends a byte, so its MSB is on MISO before the next rise.
  always_ff @(posedge clk) begin
    rx_strobe <= 1'b0;
    tx_load   <= 1'b0;
    if (rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      rx_byte  <= 8'd0;
      tx_shift <= 8'hFF;
    end else if (!selected) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'hFF;
    end else begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_sync[1]};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte   <= {rx_shift, mosi_sync[1]};
          rx_strobe <= 1'b1;
        end
      end
      if (sclk_fall) begin
        if (bit_cnt == 3'd0) begin
          tx_shift <= tx_byte;
          tx_load  <= 1'b1;
        end else begin
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/sd_spi_card_responder.sv
// rtl/sd_spi_card_responder.sv - SPI-mode SD card responder: frame FSM, card state and R1/R3/R7 response buffer
module sd_spi_card_responder
  import sd_spi_pkg::*;
#(
  parameter logic [31:0] OCR        = 32'h40FF8000,
  parameter int          INIT_POLLS = 4,
  parameter int          NCR        = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        card_ready,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg
);

  localparam logic [3:0] NCR_W = 4'(NCR);

  logic         selected;
  logic [7:0]   rx_byte;
  logic         rx_strobe;
  logic [7:0]   tx_byte;
  logic         tx_load;

  frame_state_t state;
  frame_state_t state_next;
  logic [1:0]   arg_cnt;
  logic [5:0]   frame_index;
  logic [31:0]  arg_shift;
  logic         idle;
  logic         app;
  logic [7:0]   poll_cnt;
  logic [39:0]  resp_data;
  logic [2:0]   resp_len;
  logic [3:0]   resp_idx;
  logic [3:0]   resp_total;
  logic [2:0]   byte_sel;
  logic [39:0]  resp_shifted;

  logic         idle_n;
  logic         app_n;
  logic [7:0]   poll_n;
  logic         ready_n;
  logic [7:0]   r1;
  logic [31:0]  extra;
  logic [2:0]   len_n;

  sd_spi_byte_io u_byte_io (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .selected  (selected),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .tx_byte   (tx_byte),
    .tx_load   (tx_load)
  );

  assign resp_total   = NCR_W + {1'b0, resp_len};
  assign byte_sel     = 3'(resp_idx - NCR_W);
  assign resp_shifted = resp_data << {byte_sel, 3'b000};

  always_comb begin
    state_next = state;
    if (!selected) begin
      state_next = ST_HUNT;
    end else if (rx_strobe) begin
      case (state)
        ST_HUNT: if (rx_byte[7:6] == 2'b01) state_next = ST_ARG;
        ST_ARG:  if (arg_cnt == 2'd3) state_next = ST_CRC;
        ST_CRC:  state_next = ST_RESP;
        // Leave only once the final response byte has been fully clocked out.
        ST_RESP: if (resp_idx == resp_total) state_next = ST_HUNT;
        default: state_next = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'hFF;
    if (state == ST_RESP && resp_idx >= NCR_W && resp_idx < resp_total) begin
      tx_byte = resp_shifted[39:32];
    end
  end

  always_comb begin
    idle_n  = idle;
    app_n   = 1'b0;
    poll_n  = poll_cnt;
    ready_n = card_ready;
    r1      = r1_byte(idle, 1'b1);
    extra   = 32'h0;
    len_n   = 3'(R1_LEN);
    case (frame_index)
      CMD0: begin
        idle_n  = 1'b1;
        poll_n  = 8'd0;
        ready_n = 1'b0;
        r1      = r1_byte(1'b1, 1'b0);
      end
      CMD8: begin
        r1    = r1_byte(idle, 1'b0);
        extra = {16'h0000, 4'h0, arg_shift[11:8], arg_shift[7:0]};
        len_n = 3'(R7_LEN);
      end
      CMD58: begin
        r1    = r1_byte(idle, 1'b0);
        extra = {card_ready, OCR[30:0]};
        len_n = 3'(R3_LEN);
      end
      CMD55: begin
        app_n = 1'b1;
        r1    = r1_byte(idle, 1'b0);
      end
      CMD41: begin
        if (app) begin
          if (poll_cnt != 8'hFF) poll_n = poll_cnt + 8'd1;
          if ((32'(poll_cnt) + 32'd1) >= 32'(INIT_POLLS)) begin
            idle_n  = 1'b0;
            ready_n = 1'b1;
            r1      = 8'h00;
          end else begin
            r1 = 8'h01;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_HUNT;
      arg_cnt     <= 2'd0;
      frame_index <= 6'd0;
      arg_shift   <= 32'd0;
      idle        <= 1'b1;
      app         <= 1'b0;
      poll_cnt    <= 8'd0;
      card_ready  <= 1'b0;
      resp_data   <= 40'hFF_FFFF_FFFF;
      resp_len    <= 3'd0;
      resp_idx    <= 4'd0;
      cmd_valid   <= 1'b0;
      cmd_index   <= 6'd0;
      cmd_arg     <= 32'd0;
    end else begin
      state     <= state_next;
      cmd_valid <= 1'b0;
      if (rx_strobe) begin
        case (state)
          ST_HUNT: begin
            frame_index <= rx_byte[5:0];
            arg_cnt     <= 2'd0;
          end
          ST_ARG: begin
            arg_shift <= {arg_shift[23:0], rx_byte};
            arg_cnt   <= arg_cnt + 2'd1;
          end
          ST_CRC: begin
            cmd_valid  <= 1'b1;
            cmd_index  <= frame_index;
            cmd_arg    <= arg_shift;
            idle       <= idle_n;
            app        <= app_n;
            poll_cnt   <= poll_n;
            card_ready <= ready_n;
            resp_data  <= {r1, extra};
            resp_len   <= len_n;
            resp_idx   <= 4'd0;
          end
          default: ;
        endcase
      end
      if (tx_load && state == ST_RESP) resp_idx <= resp_idx + 4'd1;
    end
  end

endmodule

// File: tb/tb_sd_spi_card_responder.sv
// tb/tb_sd_spi_card_responder.sv - directed table-driven bench for the SD SPI card responder
module tb_sd_spi_card_responder;

  localparam int HALF = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic        card_ready;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  int n_cmp = 0;
  int n_bad = 0;
  int valid_seen = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    int          n;
    logic [63:0] exp;
    logic        ready;
  } vec_t;

  vec_t vecs [13];

  always #5 clk = ~clk;

  sd_spi_card_responder dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sclk   (spi_sclk),
    .spi_cs_n   (spi_cs_n),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .card_ready (card_ready),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg)
  );

  always @(posedge clk) if (cmd_valid) valid_seen <= valid_seen + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, output logic [7:0] miso_and);
    logic [7:0] frame [6];
    logic [7:0] rb;
    frame[0] = {2'b01, idx};
    frame[1] = arg[31:24];
    frame[2] = arg[23:16];
    frame[3] = arg[15:8];
    frame[4] = arg[7:0];
    frame[5] = (idx == 6'd0) ? 8'h95 : (idx == 6'd8) ? 8'h87 : 8'hFF;
    miso_and = 8'hFF;
    for (int k = 0; k < 6; k++) begin
      spi_byte(frame[k], rb);
      miso_and = miso_and & rb;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input int n, input logic [63:0] exp);
    logic [7:0]  miso_and;
    logic [7:0]  rb;
    logic [63:0] got;
    int          v0;
    v0  = valid_seen;
    got = 64'h0;
    cs_low();
    send_frame(idx, arg, miso_and);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'hFF, rb);
      got[63 - 8 * k -: 8] = rb;
    end
    cs_high();
    check({tag, " frame_miso"}, miso_and, 8'hFF);
    check({tag, " resp"}, got, exp);
    check({tag, " cmd_valid_count"}, valid_seen - v0, 1);
    check({tag, " cmd_index"}, cmd_index, idx);
    check({tag, " cmd_arg"}, cmd_arg, arg);
  endtask

  task automatic abort_after_three(input string tag, input logic exp_ready);
    logic [7:0] rb;
    int v0;
    v0 = valid_seen;
    cs_low();
    spi_byte(8'h40, rb);
    spi_byte(8'h00, rb);
    spi_byte(8'h00, rb);
    cs_high();
    check({tag, " no_valid"}, valid_seen - v0, 0);
    check({tag, " miso_idle"}, spi_miso, 1'b1);
    check({tag, " ready_kept"}, card_ready, exp_ready);
  endtask

  initial begin
    logic [7:0] rb;
    logic [7:0] miso_and;

    rst = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b1;

    vecs[0]  = '{6'd0,  32'h0000_0000, 3, 64'hFF01FF0000000000, 1'b0};
    vecs[1]  = '{6'd8,  32'h0000_01AA, 7, 64'hFF01000001AAFF00, 1'b0};
    vecs[2]  = '{6'd41, 32'h4000_0000, 3, 64'hFF05FF0000000000, 1'b0};
    vecs[3]  = '{6'd17, 32'h0000_0200, 3, 64'hFF05FF0000000000, 1'b0};
    vecs[4]  = '{6'd55, 32'h0000_0000, 3, 64'hFF01FF0000000000, 1'b0};
    vecs[5]  = '{6'd41, 32'h4000_0000, 3, 64'hFF01FF0000000000, 1'b0};
    vecs[6]  = '{6'd55, 32'h0000_0000, 3, 64'hFF01FF0000000000, 1'b0};
    vecs[7]  = '{6'd41, 32'h4000_0000, 3, 64'hFF01FF0000000000, 1'b0};
    vecs[8]  = '{6'd55, 32'h0000_0000, 3, 64'hFF01FF0000000000, 1'b0};
    vecs[9]  = '{6'd41, 32'h4000_0000, 3, 64'hFF01FF0000000000, 1'b0};
    vecs[10] = '{6'd55, 32'h0000_0000, 3, 64'hFF01FF0000000000, 1'b0};
    vecs[11] = '{6'd41, 32'h4000_0000, 3, 64'hFF00FF0000000000, 1'b1};
    vecs[12] = '{6'd58, 32'h0000_0000, 7, 64'hFF00C0FF8000FF00, 1'b1};

    repeat (4) @(negedge clk);
    check("reset spi_miso", spi_miso, 1'b1);
    check("reset card_ready", card_ready, 1'b0);
    check("reset cmd_valid", cmd_valid, 1'b0);
    check("reset cmd_index", cmd_index, 6'd0);
    check("reset cmd_arg", cmd_arg, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      run_cmd($sformatf("v%0d", i), vecs[i].idx, vecs[i].arg, vecs[i].n, vecs[i].exp);
      check($sformatf("v%0d card_ready", i), card_ready, vecs[i].ready);
    end

    abort_after_three("abort_ready", 1'b1);
    run_cmd("cmd58_after_abort", 6'd58, 32'h0, 7, 64'hFF00C0FF8000FF00);

    cs_low();
    send_frame(6'd8, 32'h0000_01AA, miso_and);
    spi_byte(8'hFF, rb);
    check("rst_test ncr", rb, 8'hFF);
    spi_byte(8'hFF, rb);
    check("rst_test r1", rb, 8'h00);
    repeat (HALF) @(negedge clk);
    check("rst_test miso_before", spi_miso, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_test miso_after", spi_miso, 1'b1);
    check("rst_test card_ready", card_ready, 1'b0);
    check("rst_test cmd_index", cmd_index, 6'd0);
    check("rst_test cmd_arg", cmd_arg, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cs_high();
    run_cmd("cmd58_after_rst", 6'd58, 32'h0, 7, 64'hFF0140FF8000FF00);

    abort_after_three("abort_idle", 1'b0);
    run_cmd("cmd0_after_abort", 6'd0, 32'h0, 3, 64'hFF01FF0000000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
